wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, register data width.
REQ-002 Parameter: QDEPTH, 2, load-result FIFO depth (power of two, >=2).
REQ-003 Parameter: STARVE_MAX, 4, consecutive ALU wins tolerated while a load result waits.
REQ-004 clk_i  in  1  single clock; all state updates on posedge.
REQ-005 reset_n  in  1  reset, asynchronous, active-low.
REQ-006 alu_valid_i  in  1  ALU result present this cycle; the ALU source has no ready and is never back-pressured except via alu_stall_o.
REQ-007 alu_rd_i  in  5  ALU destination register.
REQ-008 alu_data_i  in  DATA_W  ALU result.
REQ-009 alu_stall_o  out  1  registered; ALU source SHALL hold its result while high.
REQ-010 ld_valid_i  in  1  load result offered.
REQ-011 ld_ready_o  out  1  load result accepted when ld_valid_i && ld_ready_o at posedge.
REQ-012 ld_rd_i  in  5  load destination register.
REQ-013 ld_data_i  in  DATA_W  load data.
REQ-014 iss_valid_i  in  1  load issued; marks iss_rd_i pending.
REQ-015 iss_rd_i  in  5  destination of issued load.
REQ-016 busy_o  out  32  pending-load scoreboard, bit n = register n awaiting load writeback.
REQ-017 RDaddr_o  out  5  register file write address, registered.
REQ-018 RDdata_o  out  DATA_W  register file write data, registered.
REQ-019 RegWrite_o  out  1  register file write enable, registered.

Function
REQ-020 Block SHALL drive at most one register file write per cycle; RDaddr_o/RDdata_o/RegWrite_o change only on posedge.
REQ-021 Load results SHALL enter a QDEPTH-entry FIFO; no bypass, so minimum load latency is 2 cycles (accept edge, then write edge).
REQ-022 ld_ready_o SHALL equal (FIFO count < QDEPTH), derived from registered count only; push and pop in the same cycle while full is not permitted (ready is low).
REQ-023 Per cycle winner: alu_valid_i && !alu_stall_o -> ALU result written at next edge (1-cycle latency); else FIFO non-empty -> FIFO head written and popped; else RegWrite_o=0.
REQ-024 Starvation counter (3 bits min) SHALL increment each cycle ALU wins while FIFO non-empty; clear when FIFO pops or FIFO empty.
REQ-025 alu_stall_o SHALL assert for exactly the cycle after counter reaches STARVE_MAX; in that cycle alu_valid_i is ignored and FIFO head is written; counter clears.
REQ-026 Any winning entry with rd==0 SHALL produce RegWrite_o=0 (RDaddr_o/RDdata_o don't care); FIFO entry still popped.
REQ-027 busy_o bit iss_rd_i SHALL set at the edge where iss_valid_i=1 and iss_rd_i!=0.
REQ-028 busy_o bit SHALL clear at the edge where a FIFO entry with that rd is popped.
REQ-029 Simultaneous set and clear of the same bit: set wins (bit stays 1).
REQ-030 busy_o[0] SHALL be constant 0.
REQ-031 ALU writes SHALL NOT modify busy_o.
REQ-032 FIFO pointers wrap modulo QDEPTH; count range 0..QDEPTH, never overflows or underflows.

Reset
REQ-033 reset_n low SHALL asynchronously force RegWrite_o=0, RDaddr_o=0, RDdata_o=0, alu_stall_o=0, busy_o=0, FIFO empty, counter 0; ld_ready_o=1 during and after reset.
REQ-034 Reset mid-operation SHALL discard all queued load results and pending busy bits; no write issues in the first cycle after release unless alu_valid_i is high.

Verification
REQ-035 ALU only: alu_valid_i=1, rd=5, data=0xDEADBEEF -> next edge RegWrite_o=1, RDaddr_o=5, RDdata_o=0xDEADBEEF; busy_o unchanged.
REQ-036 Load only: iss rd=7, then ld rd=7 data=0x1234 accepted -> busy_o[7]=1 until write edge 2 cycles after accept, RDdata_o=0x1234, then busy_o[7]=0.
REQ-037 Conflict: ALU rd=3 and load rd=4 valid together, FIFO empty -> ALU written first edge, load written following edge (ALU idle).
REQ-038 Full/back-pressure: alu_valid_i held 1, push 2 loads -> ld_ready_o=0; after 4 ALU wins alu_stall_o=1 one cycle, FIFO head written, ld_ready_o returns 1.
REQ-039 Edge cases: load to rd=0 -> no RegWrite_o, FIFO pops; iss rd=9 coincident with pop of rd=9 -> busy_o[9] remains 1.
REQ-040 Reset: assert reset_n=0 with 2 queued loads and busy_o=0x00000280 -> immediately busy_o=0, ld_ready_o=1, RegWrite_o=0; no load writes after release.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus bundle: ALU result, load result, load issue and register-file write port.
// The arbiter sits on the slave side; the master modport is for whatever drives the sources.
interface wb_arbiter_if #(
  parameter int unsigned DATA_W = 32
);
  logic              alu_valid_i;
  logic [4:0]        alu_rd_i;
  logic [DATA_W-1:0] alu_data_i;
  logic              alu_stall_o;
  logic              ld_valid_i;
  logic              ld_ready_o;
  logic [4:0]        ld_rd_i;
  logic [DATA_W-1:0] ld_data_i;
  logic              iss_valid_i;
  logic [4:0]        iss_rd_i;
  logic [31:0]       busy_o;
  logic [4:0]        RDaddr_o;
  logic [DATA_W-1:0] RDdata_o;
  logic              RegWrite_o;

  modport slave (
    input  alu_valid_i, alu_rd_i, alu_data_i,
    input  ld_valid_i, ld_rd_i, ld_data_i,
    input  iss_valid_i, iss_rd_i,
    output alu_stall_o, ld_ready_o, busy_o,
    output RDaddr_o, RDdata_o, RegWrite_o
  );

  modport master (
    output alu_valid_i, alu_rd_i, alu_data_i,
    output ld_valid_i, ld_rd_i, ld_data_i,
    output iss_valid_i, iss_rd_i,
    input  alu_stall_o, ld_ready_o, busy_o,
    input  RDaddr_o, RDdata_o, RegWrite_o
  );
endinterface

// File: rtl/wb_arbiter.sv
// Single-port register-file writeback arbiter: ALU results take priority, load results queue
// in a small FIFO, and a starvation counter forces a load drain after STARVE_MAX ALU wins.
module wb_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned QDEPTH     = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic       clk_i,
  input logic       reset_n,
  wb_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
  localparam int unsigned STV_R = $clog2(STARVE_MAX + 1);
  localparam int unsigned STV_W = (STV_R < 3) ? 3 : STV_R;

  logic [4:0]        r_fifo_rd   [QDEPTH];
  logic [DATA_W-1:0] r_fifo_data [QDEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic [STV_W-1:0]  r_starve;
  logic              r_stall;
  logic [31:0]       r_busy;
  logic              r_regwrite;
  logic [4:0]        r_rdaddr;
  logic [DATA_W-1:0] r_rddata;

  logic              w_fifo_empty;
  logic              w_ld_ready;
  logic              w_push;
  logic              w_pop;
  logic              w_alu_win;
  logic [4:0]        w_head_rd;
  logic [DATA_W-1:0] w_head_data;
  logic [STV_W-1:0]  w_starve_nxt;
  logic [31:0]       w_busy_nxt;

  // Winner selection, starvation and scoreboard next-state
  always_comb begin
    w_fifo_empty = (r_count == '0);
    w_ld_ready   = (r_count < CNT_W'(QDEPTH));
    w_push       = bus.ld_valid_i && w_ld_ready;
    w_alu_win    = bus.alu_valid_i && !r_stall;
    w_pop        = !w_alu_win && !w_fifo_empty;
    w_head_rd    = r_fifo_rd[r_rptr];
    w_head_data  = r_fifo_data[r_rptr];

    w_starve_nxt = '0;
    if (w_alu_win && !w_fifo_empty) begin
      w_starve_nxt = r_starve + STV_W'(1);
    end

    // Set is applied after clear so a coincident issue keeps the bit pending
    w_busy_nxt = r_busy;
    if (w_pop) begin
      w_busy_nxt[w_head_rd] = 1'b0;
    end
    if (bus.iss_valid_i && (bus.iss_rd_i != 5'd0)) begin
      w_busy_nxt[bus.iss_rd_i] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // FIFO storage is written only on accept and needs no reset
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_rd[r_wptr]   <= bus.ld_rd_i;
      r_fifo_data[r_wptr] <= bus.ld_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_starve   <= '0;
      r_stall    <= 1'b0;
      r_busy     <= '0;
      r_regwrite <= 1'b0;
      r_rdaddr   <= '0;
      r_rddata   <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase

      r_starve <= w_starve_nxt;
      r_stall  <= (w_starve_nxt == STV_W'(STARVE_MAX));
      r_busy   <= w_busy_nxt;

      // Writes to x0 still consume the slot but never reach the register file
      if (w_alu_win) begin
        r_regwrite <= (bus.alu_rd_i != 5'd0);
        r_rdaddr   <= bus.alu_rd_i;
        r_rddata   <= bus.alu_data_i;
      end else if (w_pop) begin
        r_regwrite <= (w_head_rd != 5'd0);
        r_rdaddr   <= w_head_rd;
        r_rddata   <= w_head_data;
      end else begin
        r_regwrite <= 1'b0;
      end
    end
  end

  assign bus.alu_stall_o = r_stall;
  assign bus.ld_ready_o  = w_ld_ready;
  assign bus.busy_o      = r_busy;
  assign bus.RDaddr_o    = r_rdaddr;
  assign bus.RDdata_o    = r_rddata;
  assign bus.RegWrite_o  = r_regwrite;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: ALU/load priority, FIFO back-pressure, starvation stall,
// x0 writes, scoreboard set/clear collision and mid-operation reset.
module tb_wb_arbiter;

  localparam int unsigned DATA_W = 32;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  wb_arbiter_if #(.DATA_W(DATA_W)) bus ();

  wb_arbiter #(
    .DATA_W    (DATA_W),
    .QDEPTH    (2),
    .STARVE_MAX(4)
  ) dut (
    .clk_i  (clk),
    .reset_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid_i = 1'b0;
    bus.alu_rd_i    = 5'd0;
    bus.alu_data_i  = '0;
    bus.ld_valid_i  = 1'b0;
    bus.ld_rd_i     = 5'd0;
    bus.ld_data_i   = '0;
    bus.iss_valid_i = 1'b0;
    bus.iss_rd_i    = 5'd0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    bus.alu_valid_i = 1'b1;
    bus.alu_rd_i    = rd;
    bus.alu_data_i  = d;
  endtask

  task automatic ld(input logic [4:0] rd, input logic [31:0] d);
    bus.ld_valid_i = 1'b1;
    bus.ld_rd_i    = rd;
    bus.ld_data_i  = d;
  endtask

  task automatic iss(input logic [4:0] rd);
    bus.iss_valid_i = 1'b1;
    bus.iss_rd_i    = rd;
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] rd, input logic [31:0] d);
    chk({tag, ".we"},   32'(bus.RegWrite_o), 32'd1);
    chk({tag, ".addr"}, 32'(bus.RDaddr_o),   32'(rd));
    chk({tag, ".data"}, bus.RDdata_o,        d);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    idle();
    rst_n = 1'b0;
    #2;
    chk("rst.we",    32'(bus.RegWrite_o),  32'd0);
    chk("rst.addr",  32'(bus.RDaddr_o),    32'd0);
    chk("rst.data",  bus.RDdata_o,         32'd0);
    chk("rst.stall", 32'(bus.alu_stall_o), 32'd0);
    chk("rst.busy",  bus.busy_o,           32'd0);
    chk("rst.ready", 32'(bus.ld_ready_o),  32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst.we", 32'(bus.RegWrite_o), 32'd0);

    // ALU only
    alu(5'd5, 32'hDEADBEEF);
    tick();
    chk_wr("alu", 5'd5, 32'hDEADBEEF);
    chk("alu.busy", bus.busy_o, 32'd0);
    idle();
    tick();
    chk("alu_idle.we", 32'(bus.RegWrite_o), 32'd0);

    // Load only: issue, accept, write two edges later
    iss(5'd7);
    tick();
    idle();
    chk("ld.busy_set", bus.busy_o, 32'h0000_0080);
    ld(5'd7, 32'h1234);
    chk("ld.ready", 32'(bus.ld_ready_o), 32'd1);
    tick();
    idle();
    chk("ld.accept_we", 32'(bus.RegWrite_o), 32'd0);
    chk("ld.busy_hold", bus.busy_o, 32'h0000_0080);
    tick();
    chk_wr("ld", 5'd7, 32'h1234);
    chk("ld.busy_clr", bus.busy_o, 32'd0);

    // Conflict: ALU first, load on the following edge
    alu(5'd3, 32'h33);
    ld(5'd4, 32'h44);
    tick();
    idle();
    chk_wr("cf.alu", 5'd3, 32'h33);
    tick();
    chk_wr("cf.ld", 5'd4, 32'h44);
    tick();
    chk("cf.idle_we", 32'(bus.RegWrite_o), 32'd0);

    // Back-pressure and starvation
    alu(5'd1, 32'h11);
    ld(5'd8, 32'h88);
    tick();
    ld(5'd9, 32'h99);
    tick();
    bus.ld_valid_i = 1'b0;
    chk("sv.ready_full", 32'(bus.ld_ready_o), 32'd0);
    tick();
    tick();
    chk("sv.no_stall3", 32'(bus.alu_stall_o), 32'd0);
    chk_wr("sv.alu4", 5'd1, 32'h11);
    tick();
    chk("sv.stall", 32'(bus.alu_stall_o), 32'd1);
    chk("sv.ready_still_full", 32'(bus.ld_ready_o), 32'd0);
    tick();
    chk_wr("sv.drain", 5'd8, 32'h88);
    chk("sv.stall_off", 32'(bus.alu_stall_o), 32'd0);
    chk("sv.ready_back", 32'(bus.ld_ready_o), 32'd1);
    idle();
    tick();
    chk_wr("sv.drain2", 5'd9, 32'h99);
    tick();
    chk("sv.idle_we", 32'(bus.RegWrite_o), 32'd0);

    // Load to x0 is popped silently; the next entry follows immediately
    ld(5'd0, 32'h55);
    tick();
    ld(5'd10, 32'hAA);
    tick();
    bus.ld_valid_i = 1'b0;
    chk("x0.we", 32'(bus.RegWrite_o), 32'd0);
    tick();
    chk_wr("x0.next", 5'd10, 32'hAA);

    // Issue coincident with pop of the same rd keeps the bit set
    iss(5'd9);
    tick();
    idle();
    ld(5'd9, 32'h9);
    tick();
    idle();
    iss(5'd9);
    tick();
    idle();
    chk_wr("col.pop", 5'd9, 32'h9);
    chk("col.busy", bus.busy_o, 32'h0000_0200);

    // Reset with two queued loads and busy = 0x280
    iss(5'd7);
    tick();
    idle();
    alu(5'd2, 32'h22);
    ld(5'd7, 32'h77);
    tick();
    ld(5'd9, 32'h99);
    tick();
    bus.ld_valid_i = 1'b0;
    chk("mr.busy_pre", bus.busy_o, 32'h0000_0280);
    chk("mr.ready_pre", 32'(bus.ld_ready_o), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mr.busy", bus.busy_o, 32'd0);
    chk("mr.ready", 32'(bus.ld_ready_o), 32'd1);
    chk("mr.we", 32'(bus.RegWrite_o), 32'd0);
    idle();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("mr.no_wr%0d", i), 32'(bus.RegWrite_o), 32'd0);
    end
    chk("mr.busy_after", bus.busy_o, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
